// File: rtl/processador_noite_if.sv
// Night-processor bus: control-unit inputs and night-result outputs.
interface processador_noite_if #(
  parameter int unsigned N_JOGADORES = 8,
  parameter int unsigned W_ID        = 3
);
  logic                     limpa;
  logic                     processar_acao;
  logic                     confirma;
  logic                     resolver;
  logic [W_ID-1:0]          jogador_atual;
  logic [W_ID-1:0]          alvo;
  logic [2*N_JOGADORES-1:0] classes;
  logic [N_JOGADORES-1:0]   vivos;

  logic                     acao_ok;
  logic                     acao_rej;
  logic                     revela_valido;
  logic [1:0]               revela_classe;
  logic                     pronto;
  logic                     vitima_valida;
  logic [W_ID-1:0]          vitima;
  logic [2:0]               db_estado;

  // Control side: drives the night inputs, observes the results.
  modport master (
    output limpa, processar_acao, confirma, resolver, jogador_atual, alvo, classes, vivos,
    input  acao_ok, acao_rej, revela_valido, revela_classe, pronto, vitima_valida, vitima,
           db_estado
  );

  // Processor side.
  modport slave (
    input  limpa, processar_acao, confirma, resolver, jogador_atual, alvo, classes, vivos,
    output acao_ok, acao_rej, revela_valido, revela_classe, pronto, vitima_valida, vitima,
           db_estado
  );
endinterface

// File: rtl/processador_noite.sv
// Night-phase processor: collects per-class night actions, then scans the wolf vote
// tally one player per clock and resolves it into a single victim (or none).
module processador_noite #(
  parameter int unsigned N_JOGADORES = 8,
  parameter int unsigned W_ID        = 3
) (
  input logic                clock,
  input logic                reset,
  processador_noite_if.slave bus
);
  localparam int unsigned     W_V       = $clog2(N_JOGADORES + 1);
  localparam logic [W_V-1:0]  VotoMax   = W_V'(N_JOGADORES);
  localparam logic [W_ID-1:0] UltimoIdx = W_ID'(N_JOGADORES - 1);

  localparam logic [1:0] ClsAldeao  = 2'b00;
  localparam logic [1:0] ClsLobo    = 2'b01;
  localparam logic [1:0] ClsMedico  = 2'b10;
  localparam logic [1:0] ClsVidente = 2'b11;

  typedef enum logic [1:0] {
    StColeta = 2'd0,
    StConta  = 2'd1,
    StDecide = 2'd2,
    StPronto = 2'd3
  } estado_e;

  estado_e r_estado, w_estado_prox;

  logic [W_V-1:0]         r_votos [N_JOGADORES];
  logic [N_JOGADORES-1:0] r_ja_agiu;
  logic [W_ID-1:0]        r_protegido;
  logic                   r_protegido_valido;
  logic                   r_revela_valido;
  logic [1:0]             r_revela_classe;
  logic                   r_pronto;
  logic                   r_vitima_valida;
  logic [W_ID-1:0]        r_vitima;
  logic                   r_acao_ok;
  logic                   r_acao_rej;
  logic [W_ID-1:0]        r_scan;
  logic [W_ID-1:0]        r_idx;
  logic [W_V-1:0]         r_max;
  logic                   r_empate;

  logic                   w_ator_vivo;
  logic                   w_ator_agiu;
  logic [1:0]             w_ator_classe;
  logic                   w_alvo_vivo;
  logic [1:0]             w_alvo_classe;
  logic [W_V-1:0]         w_voto_scan;
  logic                   w_ator_no_range;
  logic                   w_alvo_no_range;
  logic                   w_tentativa;
  logic                   w_aceita;
  logic                   w_vitima_ok;

  // Per-player lookups by index; loops keep indexing width-safe for any N/W_ID pair.
  always_comb begin
    w_ator_vivo   = 1'b0;
    w_ator_agiu   = 1'b0;
    w_ator_classe = ClsAldeao;
    w_alvo_vivo   = 1'b0;
    w_alvo_classe = ClsAldeao;
    w_voto_scan   = '0;
    for (int unsigned i = 0; i < N_JOGADORES; i++) begin
      if (bus.jogador_atual == W_ID'(i)) begin
        w_ator_vivo   = bus.vivos[i];
        w_ator_agiu   = r_ja_agiu[i];
        w_ator_classe = bus.classes[2*i +: 2];
      end
      if (bus.alvo == W_ID'(i)) begin
        w_alvo_vivo   = bus.vivos[i];
        w_alvo_classe = bus.classes[2*i +: 2];
      end
      if (r_scan == W_ID'(i)) begin
        w_voto_scan = r_votos[i];
      end
    end
  end

  // Accept/reject decision; villagers only pass, so their target is not checked.
  always_comb begin
    w_ator_no_range = (32'(bus.jogador_atual) < N_JOGADORES);
    w_alvo_no_range = (32'(bus.alvo) < N_JOGADORES);
    w_tentativa     = (r_estado == StColeta) && bus.confirma && bus.processar_acao;
    w_aceita        = w_ator_no_range && w_ator_vivo && !w_ator_agiu &&
                      ((w_ator_classe == ClsAldeao) || (w_alvo_no_range && w_alvo_vivo));
    w_vitima_ok     = (r_max != '0) && !r_empate &&
                      !(r_protegido_valido && (r_protegido == r_idx));
  end

  // Next-state logic; limpa overrides everything.
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      StColeta: if (bus.resolver) w_estado_prox = StConta;
      StConta:  if (r_scan == UltimoIdx) w_estado_prox = StDecide;
      StDecide: w_estado_prox = StPronto;
      StPronto: w_estado_prox = StPronto;
      default:  w_estado_prox = StColeta;
    endcase
    if (bus.limpa) w_estado_prox = StColeta;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= StColeta;
    else       r_estado <= w_estado_prox;
  end

  // Night datapath: action recording, tally scan and victim decision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_JOGADORES; i++) r_votos[i] <= '0;
      r_ja_agiu          <= '0;
      r_protegido        <= '0;
      r_protegido_valido <= 1'b0;
      r_revela_valido    <= 1'b0;
      r_revela_classe    <= 2'b00;
      r_pronto           <= 1'b0;
      r_vitima_valida    <= 1'b0;
      r_vitima           <= '0;
      r_acao_ok          <= 1'b0;
      r_acao_rej         <= 1'b0;
      r_scan             <= '0;
      r_idx              <= '0;
      r_max              <= '0;
      r_empate           <= 1'b0;
    end else if (bus.limpa) begin
      for (int unsigned i = 0; i < N_JOGADORES; i++) r_votos[i] <= '0;
      r_ja_agiu          <= '0;
      r_protegido        <= '0;
      r_protegido_valido <= 1'b0;
      r_revela_valido    <= 1'b0;
      r_revela_classe    <= 2'b00;
      r_pronto           <= 1'b0;
      r_vitima_valida    <= 1'b0;
      r_vitima           <= '0;
      r_acao_ok          <= 1'b0;
      r_acao_rej         <= 1'b0;
      r_scan             <= '0;
      r_idx              <= '0;
      r_max              <= '0;
      r_empate           <= 1'b0;
    end else begin
      r_acao_ok  <= 1'b0;
      r_acao_rej <= 1'b0;
      r_pronto   <= (r_estado == StPronto);

      if (w_tentativa) begin
        if (w_aceita) begin
          r_acao_ok <= 1'b1;
          for (int unsigned i = 0; i < N_JOGADORES; i++) begin
            if (bus.jogador_atual == W_ID'(i)) r_ja_agiu[i] <= 1'b1;
            if ((w_ator_classe == ClsLobo) && (bus.alvo == W_ID'(i)) &&
                (r_votos[i] != VotoMax)) begin
              r_votos[i] <= r_votos[i] + 1'b1;
            end
          end
          if (w_ator_classe == ClsMedico) begin
            r_protegido        <= bus.alvo;
            r_protegido_valido <= 1'b1;
          end
          if (w_ator_classe == ClsVidente) begin
            r_revela_classe <= w_alvo_classe;
            r_revela_valido <= 1'b1;
          end
        end else begin
          r_acao_rej <= 1'b1;
        end
      end

      // Scan accumulators restart on the resolver edge; a same-cycle vote is already in place.
      if ((r_estado == StColeta) && bus.resolver) begin
        r_scan   <= '0;
        r_idx    <= '0;
        r_max    <= '0;
        r_empate <= 1'b0;
      end

      if (r_estado == StConta) begin
        if (w_voto_scan > r_max) begin
          r_max    <= w_voto_scan;
          r_idx    <= r_scan;
          r_empate <= 1'b0;
        end else if ((w_voto_scan == r_max) && (r_max != '0)) begin
          r_empate <= 1'b1;
        end
        if (r_scan != UltimoIdx) r_scan <= r_scan + 1'b1;
      end

      if (r_estado == StDecide) begin
        r_vitima_valida <= w_vitima_ok;
        r_vitima        <= w_vitima_ok ? r_idx : '0;
      end
    end
  end

  // Outputs straight from registers.
  always_comb begin
    bus.acao_ok       = r_acao_ok;
    bus.acao_rej      = r_acao_rej;
    bus.revela_valido = r_revela_valido;
    bus.revela_classe = r_revela_classe;
    bus.pronto        = r_pronto;
    bus.vitima_valida = r_vitima_valida;
    bus.vitima        = r_vitima;
    bus.db_estado     = {1'b0, r_estado};
  end
endmodule

// File: tb/tb_processador_noite.sv
// Self-checking bench for processador_noite: action replies and resolution results are
// queued as expectations when stimulus is driven and compared when the DUT answers.
module tb_processador_noite;
  localparam int unsigned N = 8;
  localparam int unsigned W = 3;
  // Players: 0 seer, 1/2/6/7 wolves, 3 doctor, 4/5 villagers.
  localparam logic [2*N-1:0] ClassesBase = 16'h5097;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  processador_noite_if #(.N_JOGADORES(N), .W_ID(W)) bus ();
  processador_noite #(.N_JOGADORES(N), .W_ID(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] q_acao [$];  // {acao_ok, acao_rej}
  logic [W:0] q_res  [$];  // {vitima_valida, vitima}

  function automatic logic [12:0] saidas();
    return {bus.acao_ok, bus.acao_rej, bus.revela_valido, bus.revela_classe, bus.pronto,
            bus.vitima_valida, bus.vitima, bus.db_estado};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic limpa_noite();
    bus.limpa = 1'b1;
    tick();
    bus.limpa = 1'b0;
  endtask

  task automatic acao(input logic [W-1:0] jog, input logic [W-1:0] al, input logic pa,
                      input logic [1:0] esp, input string nome);
    logic [1:0] e;
    logic [1:0] got;
    bus.jogador_atual  = jog;
    bus.alvo           = al;
    bus.processar_acao = pa;
    bus.confirma       = 1'b1;
    q_acao.push_back(esp);
    tick();
    bus.confirma       = 1'b0;
    bus.processar_acao = 1'b0;
    e   = q_acao.pop_front();
    got = {bus.acao_ok, bus.acao_rej};
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: ok/rej=%b required %b", nome, got, e);
    end
  endtask

  task automatic resolve(input logic exp_valid, input logic [W-1:0] exp_vit, input string nome);
    int ciclos;
    logic [W:0] e;
    bus.resolver = 1'b1;
    q_res.push_back({exp_valid, exp_vit});
    tick();
    bus.resolver = 1'b0;
    n_vec++;
    if (bus.db_estado !== 3'd1) begin
      n_err++;
      $display("FAIL %s state after resolver: db_estado=%0d required 1", nome, bus.db_estado);
    end
    ciclos = 0;
    while (bus.pronto !== 1'b1 && ciclos < 40) begin
      tick();
      ciclos++;
    end
    n_vec++;
    if (ciclos != N + 2) begin
      n_err++;
      $display("FAIL %s latency: pronto after %0d cycles required %0d", nome, ciclos, N + 2);
    end
    e = q_res.pop_front();
    n_vec++;
    if ({bus.vitima_valida, bus.vitima} !== e) begin
      n_err++;
      $display("FAIL %s result: valid/vitima=%b/%0d required %b/%0d", nome,
               bus.vitima_valida, bus.vitima, e[W], e[W-1:0]);
    end
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    bus.limpa          = 1'b0;
    bus.processar_acao = 1'b0;
    bus.confirma       = 1'b0;
    bus.resolver       = 1'b0;
    bus.jogador_atual  = '0;
    bus.alvo           = '0;
    bus.classes        = ClassesBase;
    bus.vivos          = '1;
    tick();
    tick();
    n_vec++;
    if (saidas() !== 13'd0) begin
      n_err++;
      $display("FAIL reset outputs: %b required 0", saidas());
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if (bus.db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL reset state: db_estado=%0d required 0", bus.db_estado);
    end
  endtask

  task automatic test_vitima();
    limpa_noite();
    acao(3'd1, 3'd5, 1'b1, 2'b10, "wolf1->5");
    acao(3'd2, 3'd5, 1'b1, 2'b10, "wolf2->5");
    acao(3'd3, 3'd4, 1'b1, 2'b10, "doctor->4");
    resolve(1'b1, 3'd5, "victim 5");
  endtask

  task automatic test_protecao();
    limpa_noite();
    acao(3'd1, 3'd5, 1'b1, 2'b10, "wolf1->5 b");
    acao(3'd2, 3'd5, 1'b1, 2'b10, "wolf2->5 b");
    acao(3'd3, 3'd5, 1'b1, 2'b10, "doctor->5");
    resolve(1'b0, 3'd0, "protected 5");
  endtask

  task automatic test_empate();
    limpa_noite();
    acao(3'd1, 3'd2, 1'b1, 2'b10, "wolf1->2");
    acao(3'd6, 3'd4, 1'b1, 2'b10, "wolf6->4");
    resolve(1'b0, 3'd0, "tie 1-1");
    limpa_noite();
    acao(3'd1, 3'd2, 1'b1, 2'b10, "wolf1->2 b");
    acao(3'd6, 3'd4, 1'b1, 2'b10, "wolf6->4 b");
    acao(3'd7, 3'd4, 1'b1, 2'b10, "wolf7->4");
    resolve(1'b1, 3'd4, "tie broken");
  endtask

  task automatic test_rejeicao();
    limpa_noite();
    bus.vivos = 8'b1111_0111;
    acao(3'd1, 3'd5, 1'b1, 2'b10, "wolf1 first");
    acao(3'd1, 3'd3, 1'b1, 2'b01, "wolf1 duplicate");
    acao(3'd2, 3'd3, 1'b1, 2'b01, "dead target");
    acao(3'd3, 3'd5, 1'b1, 2'b01, "dead actor");
    acao(3'd0, 3'd1, 1'b0, 2'b00, "ignored confirm");
    acao(3'd0, 3'd1, 1'b1, 2'b10, "seer after ignored");
    acao(3'd4, 3'd3, 1'b1, 2'b10, "villager pass");
    resolve(1'b1, 3'd5, "rejected not counted");
    bus.vivos = '1;
  endtask

  task automatic test_vidente();
    limpa_noite();
    acao(3'd0, 3'd1, 1'b1, 2'b10, "seer->1");
    n_vec++;
    if ({bus.revela_valido, bus.revela_classe} !== 3'b101) begin
      n_err++;
      $display("FAIL seer reveal: %b required 101", {bus.revela_valido, bus.revela_classe});
    end
    resolve(1'b0, 3'd0, "no votes");
    acao(3'd1, 3'd5, 1'b1, 2'b00, "confirm in PRONTO");
    bus.resolver = 1'b1;
    tick();
    bus.resolver = 1'b0;
    n_vec++;
    if ({bus.db_estado, bus.pronto, bus.revela_valido, bus.revela_classe} !== 7'b011_1_1_01) begin
      n_err++;
      $display("FAIL hold in PRONTO: %b required 0111101",
               {bus.db_estado, bus.pronto, bus.revela_valido, bus.revela_classe});
    end
    limpa_noite();
    n_vec++;
    if (saidas() !== 13'd0) begin
      n_err++;
      $display("FAIL limpa after PRONTO: %b required 0", saidas());
    end
  endtask

  task automatic test_back_to_back();
    int ciclos;
    logic [W:0] e;
    logic [1:0] ea;
    limpa_noite();
    // Vote lands in the same cycle as resolver; it must still be counted.
    bus.jogador_atual  = 3'd2;
    bus.alvo           = 3'd3;
    bus.processar_acao = 1'b1;
    bus.confirma       = 1'b1;
    bus.resolver       = 1'b1;
    q_acao.push_back(2'b10);
    q_res.push_back({1'b1, 3'd3});
    tick();
    bus.confirma       = 1'b0;
    bus.processar_acao = 1'b0;
    bus.resolver       = 1'b0;
    ea = q_acao.pop_front();
    n_vec++;
    if ({bus.acao_ok, bus.acao_rej} !== ea) begin
      n_err++;
      $display("FAIL vote with resolver: ok/rej=%b required %b", {bus.acao_ok, bus.acao_rej}, ea);
    end
    ciclos = 0;
    while (bus.pronto !== 1'b1 && ciclos < 40) begin
      tick();
      ciclos++;
    end
    e = q_res.pop_front();
    n_vec++;
    if ({bus.vitima_valida, bus.vitima} !== e || ciclos != N + 2) begin
      n_err++;
      $display("FAIL same-cycle vote result: valid/vitima=%b/%0d after %0d required %b/%0d after %0d",
               bus.vitima_valida, bus.vitima, ciclos, e[W], e[W-1:0], N + 2);
    end
  endtask

  task automatic test_limpa_reset();
    limpa_noite();
    acao(3'd1, 3'd5, 1'b1, 2'b10, "wolf1 before limpa");
    bus.resolver = 1'b1;
    tick();
    bus.resolver = 1'b0;
    tick();
    tick();
    tick();
    n_vec++;
    if (bus.db_estado !== 3'd1) begin
      n_err++;
      $display("FAIL mid-scan state: db_estado=%0d required 1", bus.db_estado);
    end
    limpa_noite();
    n_vec++;
    if (saidas() !== 13'd0) begin
      n_err++;
      $display("FAIL limpa in CONTA: %b required 0", saidas());
    end
    acao(3'd2, 3'd5, 1'b1, 2'b10, "wolf2 before reset");
    reset = 1'b1;
    #1;
    n_vec++;
    if (saidas() !== 13'd0) begin
      n_err++;
      $display("FAIL async reset: %b required 0", saidas());
    end
    tick();
    reset = 1'b0;
    resolve(1'b0, 3'd0, "after reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vitima();
    test_protecao();
    test_empate();
    test_rejeicao();
    test_vidente();
    test_back_to_back();
    test_limpa_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
